// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between a bus master/BFM and the SRAM slave.
interface ahb_sram_slave_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hreadyout;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        output htrans, haddr, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  htrans, haddr, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave over a small zero-initialised word memory, with
// programmable OKAY wait states and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic            hclk,
    input  logic            hreset,
    ahb_sram_slave_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    state_t                       state;
    logic [2:0]                   wait_cnt;
    logic [IDX_W-1:0]             addr_q;
    logic                         write_q;
    logic [3:0]                   mask_q;
    logic                         hreadyout_q;
    logic                         hresp_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem;

    logic       can_accept;
    logic       accept;
    logic       bad;
    logic [3:0] lane_mask;
    logic       unused_htrans0;

    assign unused_htrans0 = bus.htrans[0];

    always_comb begin
        can_accept = (state == IDLE) || (state == ERR2) ||
                     (state == DATA && wait_cnt == '0);
        accept     = can_accept && bus.hready && bus.htrans[1];
        bad        = (bus.haddr >= ADDR_W'(DEPTH * 4)) ||
                     (bus.hsize > 3'd2) ||
                     (bus.hsize == 3'd1 && bus.haddr[0]) ||
                     (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00);
        case (bus.hsize)
            3'd0:    lane_mask = 4'b0001 << bus.haddr[1:0];
            3'd1:    lane_mask = 4'b0011 << {bus.haddr[1], 1'b0};
            default: lane_mask = '1;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            mask_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            mem         <= '0;
        end else begin
            // Write commits on the completing edge, which is also the edge that
            // accepts the next address, so a following read sees the new data.
            if (state == DATA && wait_cnt == '0 && write_q) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (mask_q[k]) mem[addr_q][8*k +: 8] <= bus.hwdata[8*k +: 8];
                end
            end

            if (accept) begin
                addr_q  <= bus.haddr[IDX_W+1:2];
                write_q <= bus.hwrite;
                mask_q  <= lane_mask;
                if (bad) begin
                    state       <= ERR1;
                    wait_cnt    <= '0;
                    hreadyout_q <= 1'b0;
                    hresp_q     <= 1'b1;
                end else begin
                    state       <= DATA;
                    wait_cnt    <= 3'(WAIT_STATES);
                    hreadyout_q <= (WAIT_STATES == 0);
                    hresp_q     <= 1'b0;
                end
            end else if (state == ERR1) begin
                state       <= ERR2;
                hreadyout_q <= 1'b1;
            end else if (state == DATA && wait_cnt != '0) begin
                wait_cnt    <= wait_cnt - 3'd1;
                hreadyout_q <= (wait_cnt == 3'd1);
            end else begin
                state       <= IDLE;
                hreadyout_q <= 1'b1;
                hresp_q     <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.hrdata = '0;
        if (state == DATA && !write_q) bus.hrdata = mem[addr_q];
    end

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances with different wait
// states, randomized transfers checked against a byte-level memory model.
module tb_ahb_sram_slave;
    localparam int unsigned N_INST = 3;
    localparam int unsigned WS_TAB [N_INST] = '{0, 2, 3};

    typedef struct packed {
        logic        err;
        logic        wr;
        logic [31:0] rdata;
    } exp_t;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic [1:0]  htrans_d [N_INST];
    logic [31:0] haddr_d  [N_INST];
    logic        hwrite_d [N_INST];
    logic [2:0]  hsize_d  [N_INST];
    logic [31:0] hwdata_d [N_INST];
    logic        stall_d  [N_INST];
    logic        rst_d    [N_INST];
    logic        rst_q    [N_INST];
    logic        hready_m [N_INST];
    logic        rdyout_m [N_INST];
    logic        resp_m   [N_INST];
    logic [31:0] rdata_m  [N_INST];

    logic [31:0] model_mem [N_INST][16];
    exp_t        expq [N_INST][$];
    int unsigned pcnt [N_INST];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    for (genvar g = 0; g < N_INST; g++) begin : gi
        ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();
        assign bus.htrans   = htrans_d[g];
        assign bus.haddr    = haddr_d[g];
        assign bus.hwrite   = hwrite_d[g];
        assign bus.hsize    = hsize_d[g];
        assign bus.hwdata   = hwdata_d[g];
        assign bus.hready   = bus.hreadyout & ~stall_d[g];
        assign hready_m[g]  = bus.hready;
        assign rdyout_m[g]  = bus.hreadyout;
        assign resp_m[g]    = bus.hresp;
        assign rdata_m[g]   = bus.hrdata;

        ahb_sram_slave #(
            .ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(WS_TAB[g])
        ) dut (
            .hclk(hclk), .hreset(rst_d[g]), .bus(bus)
        );
    end

    always @(posedge hclk) begin
        for (int i = 0; i < N_INST; i++) rst_q[i] <= rst_d[i];
    end

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s inst%0d t=%0t: got %h, expected %h", name, i, $time, act, req);
        end
    endtask

    // Monitor: one response check per instance per cycle against the queue head.
    always @(negedge hclk) begin
        exp_t e;
        for (int i = 0; i < N_INST; i++) begin
            if (rst_q[i]) begin
                expq[i].delete();
                pcnt[i] = 0;
                chk("reset_hreadyout", i, 32'(rdyout_m[i]), 32'd1);
                chk("reset_hresp", i, 32'(resp_m[i]), 32'd0);
                chk("reset_hrdata", i, rdata_m[i], 32'd0);
            end else if (expq[i].size() == 0) begin
                chk("idle_hreadyout", i, 32'(rdyout_m[i]), 32'd1);
                chk("idle_hresp", i, 32'(resp_m[i]), 32'd0);
                chk("idle_hrdata", i, rdata_m[i], 32'd0);
            end else begin
                e = expq[i][0];
                pcnt[i]++;
                if (e.err) begin
                    chk("err_hresp", i, 32'(resp_m[i]), 32'd1);
                    chk("err_hreadyout", i, 32'(rdyout_m[i]), (pcnt[i] == 2) ? 32'd1 : 32'd0);
                    if (pcnt[i] >= 2) begin
                        void'(expq[i].pop_front());
                        pcnt[i] = 0;
                    end
                end else begin
                    chk("okay_hresp", i, 32'(resp_m[i]), 32'd0);
                    chk("okay_hreadyout", i, 32'(rdyout_m[i]),
                        (pcnt[i] == WS_TAB[i] + 1) ? 32'd1 : 32'd0);
                    if (e.wr) chk("write_hrdata", i, rdata_m[i], 32'd0);
                    else      chk("read_hrdata", i, rdata_m[i], e.rdata);
                    if (pcnt[i] >= WS_TAB[i] + 1) begin
                        void'(expq[i].pop_front());
                        pcnt[i] = 0;
                    end
                end
            end
        end
    end

    function automatic logic is_bad(logic [31:0] addr, logic [2:0] size);
        return (addr >= 32'd64) || (size > 3'd2) ||
               (size == 3'd1 && addr % 2 != 0) || (size == 3'd2 && addr % 4 != 0);
    endfunction

    function automatic void model_write(int i, logic [31:0] addr, logic [2:0] size,
                                        logic [31:0] wdata);
        int unsigned nbytes = 1 << size;
        int unsigned first  = addr % 4;
        for (int unsigned b = first; b < first + nbytes; b++)
            model_mem[i][addr / 4][8*b +: 8] = wdata[8*b +: 8];
    endfunction

    task automatic wait_ready(int i);
        int unsigned n = 0;
        while (hready_m[i] !== 1'b1 && n < 64) begin
            @(posedge hclk); #1;
            n++;
        end
        if (n >= 64) begin
            vectors++;
            miscompares++;
            $display("FAIL hready_timeout inst%0d: hready stuck at %b, required 1", i, hready_m[i]);
        end
    endtask

    task automatic xfer(int i, logic wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wdata);
        exp_t e;
        htrans_d[i] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
        haddr_d[i]  = addr;
        hwrite_d[i] = wr;
        hsize_d[i]  = size;
        wait_ready(i);
        @(posedge hclk); #1;
        e.err   = is_bad(addr, size);
        e.wr    = wr;
        e.rdata = '0;
        if (!e.err && wr)  model_write(i, addr, size, wdata);
        if (!e.err && !wr) e.rdata = model_mem[i][addr[5:2]];
        expq[i].push_back(e);
        htrans_d[i] = 2'b00;
        hwdata_d[i] = wdata;
    endtask

    task automatic idle(int i, int n);
        htrans_d[i] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00;
        haddr_d[i]  = $urandom;
        repeat (n) begin @(posedge hclk); #1; end
        htrans_d[i] = 2'b00;
    endtask

    task automatic drain(int i);
        int unsigned n = 0;
        htrans_d[i] = 2'b00;
        while (expq[i].size() != 0 && n < 64) begin
            @(posedge hclk); #1;
            n++;
        end
        if (n >= 64) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout inst%0d: %0d responses pending, required 0", i, expq[i].size());
        end
    endtask

    task automatic do_reset(int i, int cycles);
        rst_d[i]    = 1'b1;
        htrans_d[i] = 2'b00;
        repeat (cycles) begin @(posedge hclk); #1; end
        rst_d[i] = 1'b0;
        for (int w = 0; w < 16; w++) model_mem[i][w] = '0;
    endtask

    task automatic rand_run(int i, int n);
        for (int t = 0; t < n; t++) begin
            logic [2:0]  size;
            int unsigned off;
            logic [31:0] addr;
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            off  = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0 && size <= 3'd2) off = off & ~((1 << size) - 1);
            addr = 32'($urandom_range(0, 17)) * 4 + off;
            xfer(i, 1'($urandom_range(0, 1)), addr, size, $urandom);
            if ($urandom_range(0, 4) == 0) idle(i, $urandom_range(1, 2));
        end
        drain(i);
    endtask

    initial begin
        for (int i = 0; i < N_INST; i++) begin
            htrans_d[i] = 2'b00;
            haddr_d[i]  = '0;
            hwrite_d[i] = 1'b0;
            hsize_d[i]  = 3'd0;
            hwdata_d[i] = '0;
            stall_d[i]  = 1'b0;
            rst_d[i]    = 1'b1;
            pcnt[i]     = 0;
            for (int w = 0; w < 16; w++) model_mem[i][w] = '0;
        end
        repeat (2) @(posedge hclk);
        #1;
        for (int i = 0; i < N_INST; i++) rst_d[i] = 1'b0;

        // Zero wait states: directed plan items, then a stalled address, then random.
        xfer(0, 1'b0, 32'h0, 3'd2, 32'h0);
        xfer(0, 1'b1, 32'h8, 3'd2, 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h8, 3'd2, 32'h0);
        xfer(0, 1'b1, 32'h0, 3'd2, 32'h11223344);
        xfer(0, 1'b1, 32'h0, 3'd0, 32'h000000AA);
        xfer(0, 1'b0, 32'h0, 3'd2, 32'h0);
        xfer(0, 1'b0, 32'h40, 3'd2, 32'h0);
        xfer(0, 1'b1, 32'h2, 3'd2, 32'hCAFEF00D);
        xfer(0, 1'b0, 32'h0, 3'd2, 32'h0);
        drain(0);
        stall_d[0]  = 1'b1;
        htrans_d[0] = 2'b10;
        haddr_d[0]  = 32'h8;
        hwrite_d[0] = 1'b0;
        hsize_d[0]  = 3'd2;
        repeat (3) begin @(posedge hclk); #1; end
        htrans_d[0] = 2'b00;
        stall_d[0]  = 1'b0;
        idle(0, 2);
        rand_run(0, 300);

        // Two wait states.
        xfer(1, 1'b0, 32'h4, 3'd2, 32'h0);
        drain(1);
        rand_run(1, 80);

        // Three wait states, with reset landing in the second wait cycle of a write.
        xfer(2, 1'b1, 32'h4, 3'd2, 32'hA5A5A5A5);
        xfer(2, 1'b1, 32'h0, 3'd2, 32'h00000055);
        @(posedge hclk); #1;
        do_reset(2, 1);
        xfer(2, 1'b0, 32'h0, 3'd2, 32'h0);
        xfer(2, 1'b0, 32'h4, 3'd2, 32'h0);
        drain(2);
        rand_run(2, 80);

        repeat (3) begin @(posedge hclk); #1; end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
